dmem_mmio_uart: RTL and testbench
=================================

// Module: dmem_mmio_uart
// PURPOSE
//  Data-side memory system driven by the single-cycle CPU's DM_ena/DM_W/DM_R, alu_out (address) and DM_wdata.
//  Returns DM_rdata. Decodes the address into word RAM or a memory-mapped UART transmitter.
//  The UART has a TX FIFO, so CPU stores never stall: the CPU has no stall input.
// PARAMETERS
//  RAM_WORDS     1024           RAM depth in 32-bit words, power of 2
//  RAM_BASE      32'h1001_0000  byte address of RAM word 0
//  MMIO_BASE     32'hFFFF_0000  byte address of UART register block
//  FIFO_DEPTH    8              TX FIFO entries (8-bit), power of 2, 2..128
//  CLKS_PER_BIT  16             clk cycles per UART bit, >=2
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  DM_ena     in   1   access enable
//  DM_W       in   1   write strobe (qualified by DM_ena)
//  DM_R       in   1   read strobe (qualified by DM_ena)
//  addr       in   32  byte address (CPU alu_out); addr[1:0] ignored
//  DM_wdata   in   32  store data
//  DM_rdata   out  32  load data, combinational
//  tx         out  1   UART serial out, idle high, registered
//  irq_txe    out  1   high while FIFO empty and FSM IDLE
// BEHAVIOUR
//  Decode:
//   - RAM hit: RAM_BASE <= addr < RAM_BASE+4*RAM_WORDS; index = (addr-RAM_BASE)>>2.
//   - TXDATA = MMIO_BASE+0; STATUS = MMIO_BASE+4; any other address: no hit.
//  Reads (DM_ena&DM_R), same cycle, combinational:
//   - RAM hit: RAM word.
//   - STATUS: {16'b0, count[7:0], 4'b0, ovf, full, empty, busy}.
//   - TXDATA or no hit: 32'h0.
//   - DM_ena low or DM_R low: DM_rdata=0.
//  Writes (DM_ena&DM_W) commit at the rising edge:
//   - RAM hit: whole word written. RAM is not reset; reads before first write are X.
//   - TXDATA: push DM_wdata[7:0] if not full. If full, the byte is dropped and sticky ovf is set.
//   - STATUS: any write clears ovf.
//   - No hit: ignored, no side effects.
//  FIFO:
//   - Circular, wr/rd pointers wrap at FIFO_DEPTH; count 0..FIFO_DEPTH.
//   - full = (count==FIFO_DEPTH); empty = (count==0).
//   - Push and pop in the same cycle: both happen, count unchanged. When full, pop and push same cycle still drop the push; full is evaluated before the edge.
//  TX FSM states: IDLE, START, DATA, STOP. Baud counter 0..CLKS_PER_BIT-1; bit index 0..7.
//   - IDLE: tx=1. If !empty, pop the head into the shift register, go START next edge.
//   - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
//   - DATA: LSB first, each bit held CLKS_PER_BIT cycles; after bit 7, go STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
//   - Back-to-back: IDLE lasts 1 cycle between frames, so a frame is 10*CLKS_PER_BIT+1 cycles.
//   - busy = (state!=IDLE).
//  Latency: byte pushed at edge N into empty FIFO with FSM IDLE -> pop at edge N+1, tx falls after edge N+1.
//  Reset (rst=0, any time incl. mid-frame):
//   - tx=1, state=IDLE, pointers/count=0, ovf=0, counters=0, irq_txe=1.
//   - DM_rdata follows its combinational rule.
//   - In-flight frame and queued bytes are discarded.
// TESTING
//  1. Reset -> tx=1, irq_txe=1; STATUS read = 32'h0000_0002.
//  2. SW 32'hDEADBEEF @0x1001_0010; LW 0x1001_0010 -> 32'hDEADBEEF. LW 0x1001_1000 (out of range) -> 0. SW out of range leaves RAM unchanged.
//  3. SW 32'h55 @TXDATA, CLKS_PER_BIT=4 -> tx = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each bit 4 cycles. Then busy=0, irq_txe=1.
//  4. 10 SWs to TXDATA in consecutive cycles, FIFO_DEPTH=8, FSM idle at start. First byte pops after 1 cycle, so 9 are accepted and the 10th is dropped. STATUS.ovf=1; SW STATUS -> ovf=0. Exactly 9 frames are sent in order.
//  5. FIFO full with FSM in IDLE-pop cycle plus simultaneous push -> push dropped, count becomes FIFO_DEPTH-1, ovf=1. Wrap: 3*FIFO_DEPTH bytes through the FIFO preserve order.
//  6. Assert rst mid-DATA bit 3 with 2 bytes queued -> tx=1 asynchronously, STATUS=32'h2 after release, no further frames.

Source files
------------

// File: rtl/dmem_mmio_uart.sv
// Data-side memory for the single-cycle CPU: word RAM plus a memory-mapped
// UART transmitter fed by a TX FIFO, so stores never need to stall the core.
module dmem_mmio_uart #(
  parameter int          RAM_WORDS    = 1024,
  parameter logic [31:0] RAM_BASE     = 32'h1001_0000,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_ena,
  input  logic        DM_W,
  input  logic        DM_R,
  input  logic [31:0] addr,
  input  logic [31:0] DM_wdata,
  output logic [31:0] DM_rdata,
  output logic        tx,
  output logic        irq_txe
);

  localparam int          IW          = $clog2(RAM_WORDS);
  localparam int          PW          = $clog2(FIFO_DEPTH);
  localparam int          CW          = PW + 1;
  localparam int          BW          = $clog2(CLKS_PER_BIT);
  localparam logic [32:0] RAM_SPAN    = 33'(RAM_WORDS) << 2;
  localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'd4;
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;

  logic [31:0] ram  [RAM_WORDS];
  logic [7:0]  fifo [FIFO_DEPTH];

  // Subtracting the base first lets one unsigned compare cover both range ends.
  logic [31:0]   ram_off;
  logic          ram_hit;
  logic [IW-1:0] ram_idx;
  logic          txdata_hit;
  logic          status_hit;
  logic          rd;
  logic          wr;
  logic          full;
  logic          empty;
  logic          busy;
  logic          push;
  logic          pop;
  logic [31:0]   status_word;

  assign ram_off    = addr - RAM_BASE;
  assign ram_hit    = ({1'b0, ram_off} < RAM_SPAN);
  assign ram_idx    = ram_off[IW+1:2];
  assign txdata_hit = (addr[31:2] == MMIO_BASE[31:2]);
  assign status_hit = (addr[31:2] == STATUS_ADDR[31:2]);
  assign rd         = DM_ena & DM_R;
  assign wr         = DM_ena & DM_W;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign irq_txe = empty & ~busy;
  assign pop     = ~busy & ~empty;
  assign push    = wr & txdata_hit & ~full;

  assign status_word = {16'h0, 8'(count), 4'h0, ovf, full, empty, busy};

  always_comb begin
    DM_rdata = 32'h0;
    if (rd) begin
      if (ram_hit)         DM_rdata = ram[ram_idx];
      else if (status_hit) DM_rdata = status_word;
    end
  end

  always_ff @(posedge clk) begin
    if (wr && ram_hit) ram[ram_idx] <= DM_wdata;
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= DM_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase

      // A full FIFO drops the store; software learns of it via the sticky flag.
      if (wr && status_hit)                ovf <= 1'b0;
      else if (wr && txdata_hit && full)   ovf <= 1'b1;

      case (state)
        IDLE: begin
          tx      <= 1'b1;
          baud    <= '0;
          bit_idx <= '0;
          if (!empty) begin
            shift <= fifo[rd_ptr];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud == BAUD_MAX) begin
            baud  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud == BAUD_MAX) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud == BAUD_MAX) begin
            baud  <= '0;
            state <= IDLE;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio_uart.sv
// Scoreboard bench: a cycle-level behavioural model predicts reads, tx and irq,
// while a separate UART decoder checks the byte stream against popped bytes.
module tb_dmem_mmio_uart;

  localparam int          C         = 4;
  localparam int          DEPTH     = 8;
  localparam int          RAM_WORDS = 1024;
  localparam logic [31:0] RAM_BASE  = 32'h1001_0000;
  localparam logic [31:0] MMIO      = 32'hFFFF_0000;
  localparam logic [31:0] STATUS_A  = 32'hFFFF_0004;
  localparam int          FRAME     = 10 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DM_ena = 1'b0, DM_W = 1'b0, DM_R = 1'b0;
  logic [31:0] addr = 32'h0, DM_wdata = 32'h0;
  logic [31:0] DM_rdata;
  logic        tx, irq_txe;

  dmem_mmio_uart #(
    .RAM_WORDS(RAM_WORDS), .RAM_BASE(RAM_BASE), .MMIO_BASE(MMIO),
    .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(C)
  ) dut (
    .clk(clk), .rst(rst), .DM_ena(DM_ena), .DM_W(DM_W), .DM_R(DM_R),
    .addr(addr), .DM_wdata(DM_wdata), .DM_rdata(DM_rdata),
    .tx(tx), .irq_txe(irq_txe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] rdata;
    bit          care;
    bit          is_rd;
    logic [31:0] a;
    bit          txv;
    bit          irq;
  } exp_t;

  exp_t         line_q[$];
  byte unsigned tx_exp[$];

  // Behavioural model: RAM map, byte queue, and the cycle of the last pop.
  logic [31:0]  ram_m [int];
  byte unsigned q_m[$];
  bit           ovf_m  = 1'b0;
  bit           have_m = 1'b0;
  int           now_m  = 0;
  int           t_m    = 0;
  byte unsigned cur_m  = 8'h0;

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function logic [31:0] word_of(logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function bit in_ram(logic [31:0] a);
    return (longint'(a) >= longint'(RAM_BASE)) &&
           (longint'(a) <  longint'(RAM_BASE) + 4 * RAM_WORDS);
  endfunction

  function int widx(logic [31:0] a);
    return int'((a - RAM_BASE) >> 2);
  endfunction

  function bit busy_m();
    return have_m && (now_m < t_m + FRAME);
  endfunction

  function bit tx_m();
    int idx;
    if (!busy_m()) return 1'b1;
    idx = (now_m - t_m) / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur_m[idx-1];
    return 1'b1;
  endfunction

  function logic [31:0] status_m();
    return {16'h0, 8'(q_m.size()), 4'h0, ovf_m,
            q_m.size() == DEPTH, q_m.size() == 0, busy_m()};
  endfunction

  function void model_reset();
    q_m.delete();
    tx_exp.delete();
    ovf_m  = 1'b0;
    have_m = 1'b0;
  endfunction

  // One clock cycle of bus activity; expectations refer to this cycle.
  task automatic cycle(input bit e, input bit w, input bit r,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit rst_v = 1'b1);
    exp_t x;
    bit   full_b;
    rst = rst_v; DM_ena = e; DM_W = w; DM_R = r; addr = a; DM_wdata = d;
    if (!rst_v) model_reset();
    x.rdata = 32'h0; x.care = 1'b1; x.is_rd = e && r; x.a = a;
    if (e && r) begin
      if (in_ram(a)) begin
        if (ram_m.exists(widx(a))) x.rdata = ram_m[widx(a)];
        else x.care = 1'b0;
      end else if (word_of(a) == STATUS_A) begin
        x.rdata = status_m();
      end
    end
    x.txv = tx_m();
    x.irq = (q_m.size() == 0) && !busy_m();
    line_q.push_back(x);
    @(posedge clk);
    if (rst_v) begin
      full_b = (q_m.size() == DEPTH);
      if (!busy_m() && q_m.size() > 0) begin
        cur_m  = q_m.pop_front();
        tx_exp.push_back(cur_m);
        have_m = 1'b1;
        t_m    = now_m + 1;
      end
      if (e && w) begin
        if (in_ram(a)) ram_m[widx(a)] = d;
        else if (word_of(a) == MMIO) begin
          if (full_b) ovf_m = 1'b1;
          else q_m.push_back(d[7:0]);
        end else if (word_of(a) == STATUS_A) ovf_m = 1'b0;
      end
    end
    now_m++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain();
    int g = 0;
    while ((busy_m() || q_m.size() > 0) && g < 3000) begin
      idle(1);
      g++;
    end
    chk("drain_timeout", 32'(g < 3000), 32'd1);
    idle(4);
  endtask

  // Line monitor: tx, irq and read data every cycle.
  always @(negedge clk) begin
    exp_t x;
    if (line_q.size() > 0) begin
      x = line_q.pop_front();
      chk("tx", 32'(tx), 32'(x.txv));
      chk("irq_txe", 32'(irq_txe), 32'(x.irq));
      if (x.care) chk("rdata", DM_rdata, x.rdata);
      if (x.is_rd)
        $display("read  addr=%h data=%h exp=%h%s", x.a, DM_rdata, x.rdata,
                 x.care ? "" : " (unwritten)");
    end
  end

  task automatic wait_neg(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rst) ab = 1'b1;
    end
  endtask

  // UART decoder: samples each bit mid-cell and scores whole bytes.
  int frames = 0;
  initial begin
    bit         ab;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tx === 1'b0) begin
        ab = 1'b0;
        wait_neg(C / 2, ab);
        if (!ab) chk("start_bit", 32'(tx), 32'd0);
        for (int j = 0; j < 8; j++) begin
          wait_neg(C, ab);
          b[j] = tx;
        end
        wait_neg(C, ab);
        if (!ab) begin
          chk("stop_bit", 32'(tx), 32'd1);
          if (tx_exp.size() == 0) begin
            chk("frame_unexpected", 32'(b), 32'hFFFF_FFFF);
          end else begin
            byte unsigned eb;
            eb = tx_exp.pop_front();
            chk("frame_byte", 32'(b), 32'(eb));
            $display("frame %0d byte=%h exp=%h", frames, b, eb);
          end
          frames++;
        end
      end
    end
  end

  initial begin
    int          g;
    logic [31:0] pool_a;
    int          op;
    @(posedge clk);
    #1;
    // Reset state, including a STATUS read while reset is held.
    idle(2);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, STATUS_A, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, STATUS_A, 32'h0);
    chk("status_reset_const", DM_rdata, 32'h0000_0002);

    // RAM: store/load, upper boundary, out-of-range store does not alias.
    cycle(1'b1, 1'b1, 1'b0, 32'h1001_0010, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 1'b1, 32'h1001_0010, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h1001_1000, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, RAM_BASE, 32'h1111_1111);
    cycle(1'b1, 1'b1, 1'b0, 32'h1001_0FFC, 32'h3333_3333);
    cycle(1'b1, 1'b1, 1'b0, 32'h1001_1000, 32'h2222_2222);
    cycle(1'b1, 1'b1, 1'b0, RAM_BASE - 32'd4, 32'h4444_4444);
    cycle(1'b1, 1'b0, 1'b1, RAM_BASE, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 32'h1001_0FFF, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, RAM_BASE, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, RAM_BASE, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, MMIO, 32'h0);

    // Single frame 0x55.
    cycle(1'b1, 1'b1, 1'b0, MMIO, 32'h0000_0055);
    drain();

    // Ten back-to-back pushes: nine accepted, the tenth sets ovf.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, MMIO, 32'(8'hA0 + i));
    cycle(1'b1, 1'b0, 1'b1, STATUS_A, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, STATUS_A, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, STATUS_A, 32'h0);

    // Full FIFO: push in the very cycle the FSM pops is still dropped.
    g = 0;
    while (!(!busy_m() && q_m.size() > 0) && g < 2000) begin idle(1); g++; end
    chk("pop_wait_timeout", 32'(g < 2000), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, MMIO, 32'h0000_00EE);
    cycle(1'b1, 1'b0, 1'b1, STATUS_A, 32'h0);
    cycle(1'b1, 1'b1, 1'b0, STATUS_A, 32'h0);
    drain();

    // Reset in the middle of data bit 3 with two bytes still queued.
    cycle(1'b1, 1'b1, 1'b0, MMIO, 32'h0000_00C3);
    cycle(1'b1, 1'b1, 1'b0, MMIO, 32'h0000_005A);
    cycle(1'b1, 1'b1, 1'b0, MMIO, 32'h0000_0081);
    g = 0;
    while (!(busy_m() && (now_m - t_m) == 4 * C + 1) && g < 2000) begin idle(1); g++; end
    chk("bit3_wait_timeout", 32'(g < 2000), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("tx_async_reset", 32'(tx), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, STATUS_A, 32'h0);
    idle(3 * FRAME);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      op = $urandom_range(0, 9);
      case ($urandom_range(0, 1))
        0:       pool_a = RAM_BASE + 32'(4 * $urandom_range(0, 7));
        default: pool_a = RAM_BASE + 32'(4 * $urandom_range(1016, 1023));
      endcase
      pool_a = pool_a + 32'($urandom_range(0, 3));
      case (op)
        0, 1: begin
          case ($urandom_range(0, 2))
            0:       cycle(1'b0, 1'($urandom), 1'($urandom), MMIO, $urandom);
            1:       cycle(1'b0, 1'($urandom), 1'($urandom), STATUS_A, $urandom);
            default: cycle(1'b0, 1'($urandom), 1'($urandom), pool_a, $urandom);
          endcase
        end
        2:    cycle(1'b1, 1'b1, 1'($urandom), pool_a, $urandom);
        3:    cycle(1'b1, 1'b0, 1'b1, pool_a, $urandom);
        4, 5: cycle(1'b1, 1'b1, 1'b0, MMIO + 32'($urandom_range(0, 3)), $urandom);
        6:    cycle(1'b1, 1'b0, 1'b1, STATUS_A, 32'h0);
        7:    cycle(1'b1, 1'b1, 1'($urandom), STATUS_A, $urandom);
        8: begin
          case ($urandom_range(0, 4))
            0:       pool_a = RAM_BASE - 32'd4;
            1:       pool_a = 32'h1001_1000;
            2:       pool_a = MMIO + 32'd8;
            3:       pool_a = MMIO - 32'd4;
            default: pool_a = $urandom;
          endcase
          cycle(1'b1, 1'($urandom), 1'($urandom), pool_a, $urandom);
        end
        default: cycle(1'b1, 1'b0, 1'b0, STATUS_A, $urandom);
      endcase
    end
    drain();
    @(negedge clk);
    chk("frames_outstanding", 32'(tx_exp.size()), 32'd0);
    chk("line_q_outstanding", 32'(line_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
